// File: rtl/write_retire_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : write_retire_sequencer
// Brief    : Buffers tagged write requests and replays each one as a capture
//            cycle, two retire cycles and a delayed write-back.
// Revision : 1.0
// ============================================================================
module write_retire_sequencer #(
  parameter int ADDR_W  = 5,
  parameter int BUS_W   = 9,
  parameter int DEPTH   = 2,
  parameter int MIN_DLY = 3,
  parameter int MAX_DLY = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [BUS_W-ADDR_W-1:0]  req_tag,
  input  logic [3:0]               req_delay,
  output logic                     write_en,
  output logic                     data_valid,
  output logic [0:ADDR_W-1]        addr,
  output logic [0:BUS_W-1]         retire_address,
  output logic [0:BUS_W-1]         write_address,
  output logic                     busy
);

  localparam int C_TAG_W = BUS_W - ADDR_W;
  localparam int C_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int C_CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RET1 = 3'd1,
    S_RET2 = 3'd2,
    S_WAIT = 3'd3,
    S_WB   = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Request FIFO (delay is clamped before it is stored)
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0]  r_mem_addr [DEPTH];
  logic [C_TAG_W-1:0] r_mem_tag  [DEPTH];
  logic [3:0]         r_mem_dly  [DEPTH];
  logic [C_PTR_W-1:0] r_wr_ptr;
  logic [C_PTR_W-1:0] r_rd_ptr;
  logic [C_CNT_W-1:0] r_count;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [3:0]         w_dly_clamped;

  state_t             r_state;
  state_t             w_state_nxt;

  assign w_full    = (r_count == C_CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_push    = req_valid && !w_full;
  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  assign req_ready = !w_full;

  always_comb begin
    w_dly_clamped = req_delay;
    if (req_delay < 4'(MIN_DLY)) begin
      w_dly_clamped = 4'(MIN_DLY);
    end else if (req_delay > 4'(MAX_DLY)) begin
      w_dly_clamped = 4'(MAX_DLY);
    end
  end

  // Storage carries no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= req_addr;
      r_mem_tag[r_wr_ptr]  <= req_tag;
      r_mem_dly[r_wr_ptr]  <= w_dly_clamped;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Transaction sequencer
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0]  r_addr;
  logic [C_TAG_W-1:0] r_tag;
  logic [3:0]         r_dly;
  logic [3:0]         r_wait_cnt;
  logic               r_write_en;
  logic               r_data_valid;
  logic               r_busy;
  logic [BUS_W-1:0]   r_retire_address;
  logic [BUS_W-1:0]   r_write_address;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = S_RET1;
        end
      end
      S_RET1:  w_state_nxt = S_RET2;
      S_RET2:  w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (r_wait_cnt == 4'd1) begin
          w_state_nxt = S_WB;
        end
      end
      S_WB:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_addr           <= '0;
      r_tag            <= '0;
      r_dly            <= '0;
      r_wait_cnt       <= '0;
      r_write_en       <= 1'b0;
      r_data_valid     <= 1'b0;
      r_busy           <= 1'b0;
      r_retire_address <= '0;
      r_write_address  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_write_en   <= (w_state_nxt == S_RET1) || (w_state_nxt == S_RET2) ||
                      (w_state_nxt == S_WB);
      r_data_valid <= (w_state_nxt == S_RET1);

      if (w_pop) begin
        r_addr           <= r_mem_addr[r_rd_ptr];
        r_tag            <= r_mem_tag[r_rd_ptr];
        r_dly            <= r_mem_dly[r_rd_ptr];
        r_retire_address <= {r_mem_addr[r_rd_ptr], r_mem_tag[r_rd_ptr]};
      end

      // WAIT spans D-1 cycles so WB lands exactly D cycles after RET2.
      if (r_state == S_RET2) begin
        r_wait_cnt <= r_dly - 4'd1;
      end else if (r_state == S_WAIT) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end

      if (w_state_nxt == S_WB) begin
        r_write_address <= {r_addr, r_tag};
      end
    end
  end

  assign write_en       = r_write_en;
  assign data_valid     = r_data_valid;
  assign addr           = r_addr;
  assign retire_address = r_retire_address;
  assign write_address  = r_write_address;
  assign busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_write_retire_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_write_retire_sequencer
// Brief    : Directed self-checking bench for write_retire_sequencer.
// Revision : 1.0
// ============================================================================
module tb_write_retire_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] req_addr;
  logic [3:0] req_tag;
  logic [3:0] req_delay;
  logic       write_en;
  logic       data_valid;
  logic [0:4] addr;
  logic [0:8] retire_address;
  logic [0:8] write_address;
  logic       busy;

  write_retire_sequencer #(
    .ADDR_W (5),
    .BUS_W  (9),
    .DEPTH  (2),
    .MIN_DLY(3),
    .MAX_DLY(8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_tag       (req_tag),
    .req_delay     (req_delay),
    .write_en      (write_en),
    .data_valid    (data_valid),
    .addr          (addr),
    .retire_address(retire_address),
    .write_address (write_address),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int viol    = 0;

  // Cycle n begins at posedge n after reset release.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Bus monitor: classifies each strobe cycle as RET1, RET2 or WB.
  int         ret1_c[$];
  logic [8:0] ret1_ra[$];
  logic [4:0] ret1_a[$];
  int         ret2_c[$];
  int         wb_c[$];
  logic [8:0] wb_wa[$];
  logic       prev_dv = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_dv = 1'b0;
    end else begin
      if (data_valid && !write_en) viol++;
      if (data_valid) begin
        ret1_c.push_back(cyc);
        ret1_ra.push_back(retire_address);
        ret1_a.push_back(addr);
      end else if (write_en && prev_dv) begin
        ret2_c.push_back(cyc);
      end else if (write_en) begin
        wb_c.push_back(cyc);
        wb_wa.push_back(write_address);
      end
      prev_dv = data_valid;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns the edge number at which the request was taken.
  task automatic push(input logic [4:0] a, input logic [3:0] t, input logic [3:0] d,
                      output int acc);
    req_valid = 1'b1;
    req_addr  = a;
    req_tag   = t;
    req_delay = d;
    acc = -1;
    for (int i = 0; i < 200 && acc < 0; i++) begin
      if (req_ready) acc = cyc + 1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    if (acc < 0) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_wb(input int target);
    for (int i = 0; i < 300 && wb_c.size() < target; i++) @(negedge clk);
    if (wb_c.size() < target) check("wb_timeout", wb_c.size(), target);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    if (busy) check("idle_timeout", busy, 1'b0);
    @(negedge clk);
  endtask

  logic [4:0] t2_addr  [5] = '{5'h01, 5'h1F, 5'h12, 5'h07, 5'h10};
  logic [3:0] t2_tag   [5] = '{4'h5, 4'hA, 4'h0, 4'hF, 4'h9};
  logic [3:0] t2_dly   [5] = '{4'd0, 4'd15, 4'd2, 4'd9, 4'd5};
  int         t2_exp   [5] = '{3, 8, 3, 8, 5};
  logic [8:0] t3_exp   [4] = '{9'h0C1, 9'h142, 9'h1E3, 9'h004};

  initial begin
    int acc, acc_a, acc_b, acc_c, b, bw, r1, w1;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_tag   = '0;
    req_delay = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ctrl", {write_en, data_valid, busy, req_ready}, 4'b0001);
    check("rst_buses", {addr, retire_address, write_address}, 23'd0);
    rst_n = 1'b1;

    // T1: single request, delay 3
    push(5'h0A, 4'h3, 4'd3, acc);
    check("t1_accept_edge", acc, 1);
    repeat (3) @(negedge clk);
    check("t1_wait_ctrl", {write_en, data_valid, busy}, 3'b001);
    check("t1_wait_hold", retire_address, 9'h0A3);
    wait_wb(1);
    check("t1_ret1_cycle", ret1_c[0], 2);
    check("t1_ret1_addr", ret1_a[0], 5'h0A);
    check("t1_ret1_bus", ret1_ra[0], 9'h0A3);
    check("t1_ret2_cycle", ret2_c[0], 3);
    check("t1_wb_cycle", wb_c[0], 6);
    check("t1_wb_bus", wb_wa[0], 9'h0A3);

    // T2: delay clamp boundaries
    for (int k = 0; k < 5; k++) begin
      wait_idle();
      b  = ret1_c.size();
      bw = wb_c.size();
      push(t2_addr[k], t2_tag[k], t2_dly[k], acc);
      wait_wb(bw + 1);
      check($sformatf("t2_delay_%0d", k), wb_c[bw] - ret2_c[b], t2_exp[k]);
      check($sformatf("t2_latency_%0d", k), ret1_c[b] - acc, 1);
      check($sformatf("t2_wb_bus_%0d", k), wb_wa[bw], {t2_addr[k], t2_tag[k]});
      check($sformatf("t2_ret_bus_%0d", k), ret1_ra[b], {t2_addr[k], t2_tag[k]});
    end

    // T3/T4: back-to-back pushes overflow the FIFO; held request enters on a pop
    wait_idle();
    b  = ret1_c.size();
    bw = wb_c.size();
    push(5'h0C, 4'h1, 4'd3, acc);
    push(5'h14, 4'h2, 4'd4, acc_a);
    push(5'h1E, 4'h3, 4'd3, acc_b);
    check("t3_ready_full", req_ready, 1'b0);
    push(5'h00, 4'h4, 4'd3, acc_c);
    wait_wb(bw + 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t3_order_%0d", i), ret1_ra[b + i], t3_exp[i]);
    check("t3_ret1_count", ret1_c.size() - b, 4);
    check("t4_held_accept", acc_c, ret1_c[b + 1] + 1);
    for (int i = 1; i < 4; i++)
      check($sformatf("t3_idle_gap_%0d", i), ret1_c[b + i] - wb_c[bw + i - 1], 2);
    check("t3_spacing", ret1_c[b + 2] - ret1_c[b + 1], 4 + 3);

    // T5: reset during WAIT with a second request queued
    wait_idle();
    b = ret2_c.size();
    push(5'h1F, 4'hF, 4'd8, acc);
    push(5'h11, 4'h5, 4'd4, acc);
    for (int i = 0; i < 50 && ret2_c.size() <= b; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("t5_in_wait", {busy, write_en}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_ctrl", {write_en, data_valid, busy, req_ready}, 4'b0001);
    check("t5_rst_buses", {addr, retire_address, write_address}, 23'd0);
    @(negedge clk);
    rst_n = 1'b1;
    r1 = ret1_c.size();
    w1 = wb_c.size();
    repeat (20) @(negedge clk);
    check("t5_no_ret1", ret1_c.size(), r1);
    check("t5_no_wb", wb_c.size(), w1);
    check("t5_idle", busy, 1'b0);

    // T6: normal operation resumes after reset
    b  = ret1_c.size();
    bw = wb_c.size();
    push(5'h15, 4'hC, 4'd5, acc);
    wait_wb(bw + 1);
    check("t6_latency", ret1_c[b] - acc, 1);
    check("t6_delay", wb_c[bw] - ret2_c[ret2_c.size() - 1], 5);
    check("t6_wb_bus", wb_wa[bw], 9'h15C);

    // One aborted transaction never gets its write-back
    @(negedge clk);
    check("ret1_vs_wb", ret1_c.size(), wb_c.size() + 1);
    check("ret2_vs_ret1", ret2_c.size(), ret1_c.size());
    check("dv_implies_we", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
